multiword_add_seq: RTL and testbench

Multi-cycle sequencer that performs NUM_WORDS×16-bit additions by time-multiplexing a single external adder_16bit. It sits directly around that adder. It feeds the adder's a/b/carry_in one 16-bit word per cycle, least significant word first. It captures the adder's sum and overflow at each clock edge and chains the carry into the next word. It presents the wide result with a one-cycle done pulse.

---
 rtl/multiword_add_seq.sv | 118 +++++++++++
 tb/tb_multiword_add_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_seq.sv
// Word-serial wide adder: steps one shared 16-bit adder across NUM_WORDS
// operand words, least significant first, chaining the carry between words.
module multiword_add_seq #(
  parameter int NUM_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [16*NUM_WORDS-1:0] op_a,
  input  logic [16*NUM_WORDS-1:0] op_b,
  input  logic                    carry_in,
  output logic [15:0]             add_a,
  output logic [15:0]             add_b,
  output logic                    add_cin,
  input  logic [15:0]             add_sum,
  input  logic                    add_ovf,
  output logic                    busy,
  output logic                    done,
  output logic [16*NUM_WORDS-1:0] result,
  output logic                    carry_out,
  output logic                    signed_ovf
);

  localparam int W  = 16 * NUM_WORDS;
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            sovf_q, sovf_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    sovf_d   = sovf_q;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = carry_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = a_q[16*idx_q +: 16];
        add_b   = b_q[16*idx_q +: 16];
        add_cin = carry_q;
        result_d[16*idx_q +: 16] = add_sum;
        carry_d = add_ovf;
        if (idx_q == LAST) begin
          state_d = DONE;
          cout_d  = add_ovf;
          // top word is on the adder now, so its sign bits decide overflow
          sovf_d  = (a_q[W-1] == b_q[W-1]) &&
                    (add_sum[15] != a_q[W-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      sovf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      sovf_q   <= sovf_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign result     = result_q;
  assign carry_out  = cout_q;
  assign signed_ovf = sovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq with a behavioural 16-bit adder
// attached to the add_* ports.
module tb_multiword_add_seq;

  localparam int NW = 4;
  localparam int W  = 16 * NW;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         s;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         carry_in;
  logic [15:0]  add_a, add_b, add_sum;
  logic         add_cin, add_ovf;
  logic         busy, done, carry_out, signed_ovf;
  logic [W-1:0] result;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_done = -1;
  bit   period_chk = 1'b0;

  multiword_add_seq #(.NUM_WORDS(NW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .op_a(op_a), .op_b(op_b), .carry_in(carry_in),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_ovf(add_ovf),
    .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .signed_ovf(signed_ovf)
  );

  assign {add_ovf, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 want no done");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", result, e.r);
        chk("carry_out", W'(carry_out), W'(e.c));
        chk("signed_ovf", W'(signed_ovf), W'(e.s));
      end
      if (period_chk && last_done >= 0)
        chk("done_period", W'(cyc - last_done), W'(6));
      last_done = cyc;
    end
  end

  task automatic zero_chk(input string nm);
    chk({nm, "_outs"},
        W'({busy, done, carry_out, signed_ovf, add_cin}), W'(0));
    chk({nm, "_result"}, result, '0);
    chk({nm, "_addab"}, W'({add_a, add_b}), W'(0));
  endtask

  // waits for IDLE, presents operands, returns #1 after the accept edge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic [W-1:0] er,
                       input logic ec, input logic es,
                       input bit push, input bit keep);
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: got busy=%0b want 0", busy);
    end
    op_a = a;
    op_b = b;
    carry_in = cin;
    start = 1'b1;
    if (push) exp_q.push_back('{r: er, c: ec, s: es});
    @(posedge clk);
    #1;
    chk("accept_busy", W'(busy), W'(1));
    if (!keep) start = 1'b0;
  endtask

  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic [3:0]   cin_exp;

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    op_a = {$urandom, $urandom};
    op_b = {$urandom, $urandom};
    carry_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      start = 1'b1;
      zero_chk("reset");
    end
    rst = 1'b0;
    start = 1'b0;

    // carry ripple with per-word adder port checks
    ra = 64'h0000_0000_0000_FFFF;
    rb = 64'h1;
    cin_exp = 4'b0010;
    issue(ra, rb, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < NW; k++) begin
      chk("ripple_add_a", W'(add_a), W'(ra[16*k +: 16]));
      chk("ripple_add_b", W'(add_b), W'(rb[16*k +: 16]));
      chk("ripple_add_cin", W'(add_cin), W'(cin_exp[k]));
      @(posedge clk);
      #1;
    end
    chk("ripple_done_cycle5", W'(done), W'(1));

    issue('1, '0, 1'b1, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
          64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b0);

    // start pulsed mid-run with other operands must be ignored
    issue(64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    op_a = '1;
    op_b = '1;
    carry_in = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;

    // back-to-back with start held high
    issue(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1,
          64'h0011_0022_0033_0045, 1'b0, 1'b0, 1'b1, 1'b1);
    last_done = -1;
    period_chk = 1'b1;
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
          '0, 1'b1, 1'b1, 1'b1, 1'b1);
    issue(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0,
          64'h0000_0001_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    period_chk = 1'b0;

    // reset in the second RUN cycle aborts without a done pulse
    issue(64'hDEAD_BEEF_0000_1111, 64'h1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    zero_chk("midreset");
    issue(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
          64'h2345_6789_ABCD_F001, 1'b0, 1'b0, 1'b1, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
